qe_mac_pipe: RTL
================

QE_MAC_PIPE -- requirements
Module: qe_mac_pipe

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter DATA_W, default 8, SHALL set the operand width.
REQ-003 Parameter RES_W, default 16, SHALL set the result width.
REQ-004 Parameter CNT_W, default 8, SHALL set the term-counter width.
REQ-005 Parameter SATURATE, default 1, SHALL select clamping on overflow when 1 and modulo-2^RES_W wrap when 0.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 valid_in  input  1  marks the operand beat valid in this cycle.
REQ-009 last_input  input  1  marks the final MAC term; qualified by valid_in.
REQ-010 mode  input  1  selects the beat operation: 0 = quadratic, 1 = MAC.
REQ-011 in_a, in_b, in_c, in_x  input  DATA_W each  unsigned operands.
REQ-012 valid_out  output  1  one-cycle pulse marking result valid.
REQ-013 result  output  RES_W  unsigned result.
REQ-014 overflow  output  1  true result exceeded 2^RES_W-1.
REQ-015 term_count  output  CNT_W  number of terms summed (1 for a quadratic result).
REQ-016 out_mode  output  1  mode of the beat that produced the result.

Function
REQ-017 A beat SHALL be accepted on a rising edge where valid_in=1; beats with valid_in=0 SHALL have no effect, including their last_input.
REQ-018 A mode-0 beat SHALL produce result = a*x^2 + b*x + c, evaluated at full precision, as exactly one output.
REQ-019 A mode-1 beat with last_input=0 SHALL add a*x to the accumulator, increment the term counter and produce no output.
REQ-020 A mode-1 beat with last_input=1 SHALL output accumulator + a*x with term_count = count+1, and SHALL clear the accumulator, counter and sticky overflow on the same edge.
REQ-021 The pipeline SHALL have 3 register stages.
- S1: x*x, a*x, b*x and a c/mode/last sideband.
- S2: a*(x*x) and b*x + c.
- S3: final sum or accumulate, plus output registers.
REQ-022 The outputs SHALL update on the edge 2 cycles after the accepting edge (accept at edge N, outputs at edge N+2), for a fixed latency of 2.
REQ-023 Throughput SHALL be one beat per cycle with no backpressure.
REQ-024 Back-to-back last beats SHALL each produce a separate output.
REQ-025 A MAC beat following a last beat on the next cycle SHALL start from 0.
REQ-026 Mode-0 beats interleaved within a MAC sequence SHALL produce their own output and SHALL leave the accumulator and counter unchanged.
REQ-027 The accumulator SHALL be RES_W bits wide with a sticky overflow bit that is set on any carry out of RES_W.
REQ-028 With SATURATE=1 the accumulator SHALL hold at 2^RES_W-1 once the sticky bit is set.
REQ-029 With SATURATE=1, an overflowing quadratic or final sum SHALL output result = 2^RES_W-1 with overflow=1.
REQ-030 With SATURATE=0, an overflowing quadratic or final sum SHALL output result = low RES_W bits with overflow=1.
REQ-031 term_count SHALL saturate at 2^CNT_W-1.
REQ-032 result, overflow, term_count and out_mode SHALL hold their values between valid_out pulses.

Reset
REQ-033 While reset=0, all pipeline valids, the accumulator, the counter, the sticky bit and all outputs SHALL be 0.
REQ-034 Beats in flight when reset is asserted SHALL be discarded with no output.
REQ-035 After reset deasserts, the first accepted beat SHALL behave as at power-up.

Structure
REQ-036 Package qe_mac_pkg SHALL hold the mode constants MODE_QUAD=0 and MODE_MAC=1 and the default values of DATA_W, RES_W and CNT_W.
REQ-037 A sub-module qe_sat_add SHALL implement an unsigned parametrised adder with carry-out and optional clamp, instanced for the S3 quadratic sum and for the accumulator.

Verification
REQ-038 Quadratic: mode=0, a=100, b=5, c=25, x=8, valid -> result=6465, overflow=0, term_count=1, valid_out at N+2.
REQ-039 Quadratic overflow: a=b=c=x=255 -> SATURATE=1 gives 65535 with overflow=1; SATURATE=0 gives 511 with overflow=1.
REQ-040 MAC with invalid beat: (a=100, x=8) valid, (a=20, x=3) with valid_in=0, (a=1, x=2) valid with last -> a single output of result=802, term_count=2, out_mode=1.
REQ-041 MAC overflow: two beats with a=x=255, the second last -> 65535 with overflow=1, term_count=2; an immediate new MAC beat (a=3, x=4, last) -> 12 with overflow=0.
REQ-042 Interleave: a MAC beat (a=10, x=10), then a mode-0 beat (a=1, b=1, c=1, x=1), then MAC last (a=1, x=1) -> outputs 3 (mode 0) then 101 (term_count=2).
REQ-043 Reset mid-sequence: assert reset one cycle after a MAC last beat -> no valid_out; a following MAC last beat (a=2, x=2) -> 4.

Source files
------------

// File: rtl/qe_mac_pkg.sv
// Shared constants and sideband payload for the quadratic / MAC pipeline.
package qe_mac_pkg;

    localparam logic MODE_QUAD = 1'b0;
    localparam logic MODE_MAC  = 1'b1;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_RES_W  = 16;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef struct packed {
        logic valid;
        logic mode;
        logic last;
    } qe_side_t;

endpackage

// File: rtl/qe_sat_add.sv
// Unsigned W-bit adder with carry-out, overflow chaining and optional clamp to all-ones.
module qe_sat_add #(
    parameter int unsigned W     = 16,
    parameter bit          CLAMP = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ovf_in,
    output logic [W-1:0] sum_c,
    output logic         ovf_c
);

    logic [W:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        ovf_c = full[W] | ovf_in;
        sum_c = (CLAMP && ovf_c) ? '1 : full[W-1:0];
    end

endmodule

// File: rtl/qe_mac_pipe.sv
// Three-stage pipeline: per-beat quadratic a*x^2+b*x+c, or multi-beat sum of a*x terms.
module qe_mac_pipe
    import qe_mac_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RES_W    = DEF_RES_W,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              last_input,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_x,
    output logic              valid_out,
    output logic [RES_W-1:0]  result,
    output logic              overflow,
    output logic [CNT_W-1:0]  term_count,
    output logic              out_mode
);

    localparam int unsigned P_W    = 2 * DATA_W;
    localparam int unsigned S_W    = P_W + 1;
    localparam int unsigned Q_W    = 3 * DATA_W;
    localparam int unsigned F_W    = Q_W + 1;
    localparam int unsigned WIDE_W = (F_W > RES_W) ? F_W : RES_W;

    qe_side_t s1_side_q, s1_side_d, s2_side_q, s2_side_d;
    logic [P_W-1:0]    s1_xx_q, s1_xx_d, s1_ax_q, s1_ax_d, s1_bx_q, s1_bx_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_c_q, s1_c_d;
    logic [Q_W-1:0]    s2_axx_q, s2_axx_d;
    logic [S_W-1:0]    s2_bxc_q, s2_bxc_d;
    logic [P_W-1:0]    s2_ax_q, s2_ax_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              valid_out_q, valid_out_d, overflow_q, overflow_d, out_mode_q, out_mode_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  term_count_q, term_count_d;

    logic [WIDE_W-1:0] axx_w, bxc_w, ax_w;
    logic [RES_W-1:0]  quad_sum, acc_sum;
    logic              quad_ovf, acc_ovf;

    // Operands wider than RES_W are split into a low part and an "already too big" flag.
    always_comb begin
        axx_w = WIDE_W'(s2_axx_q);
        bxc_w = WIDE_W'(s2_bxc_q);
        ax_w  = WIDE_W'(s2_ax_q);
    end

    qe_sat_add #(.W(RES_W), .CLAMP(SATURATE)) u_quad_add (
        .a      (RES_W'(axx_w)),
        .b      (RES_W'(bxc_w)),
        .ovf_in ((|(axx_w >> RES_W)) | (|(bxc_w >> RES_W))),
        .sum_c  (quad_sum),
        .ovf_c  (quad_ovf)
    );

    qe_sat_add #(.W(RES_W), .CLAMP(SATURATE)) u_acc_add (
        .a      (acc_q),
        .b      (RES_W'(ax_w)),
        .ovf_in (sticky_q | (|(ax_w >> RES_W))),
        .sum_c  (acc_sum),
        .ovf_c  (acc_ovf)
    );

    always_comb begin
        s1_side_d.valid = valid_in;
        s1_side_d.mode  = mode;
        s1_side_d.last  = valid_in & last_input;
        s1_xx_d  = P_W'(in_x) * P_W'(in_x);
        s1_ax_d  = P_W'(in_a) * P_W'(in_x);
        s1_bx_d  = P_W'(in_b) * P_W'(in_x);
        s1_a_d   = in_a;
        s1_c_d   = in_c;

        s2_side_d = s1_side_q;
        s2_axx_d  = Q_W'(s1_a_q) * Q_W'(s1_xx_q);
        s2_bxc_d  = S_W'(s1_bx_q) + S_W'(s1_c_q);
        s2_ax_d   = s1_ax_q;

        cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        acc_d        = acc_q;
        sticky_d     = sticky_q;
        cnt_d        = cnt_q;
        valid_out_d  = 1'b0;
        result_d     = result_q;
        overflow_d   = overflow_q;
        term_count_d = term_count_q;
        out_mode_d   = out_mode_q;

        if (s2_side_q.valid) begin
            if (s2_side_q.mode == MODE_QUAD) begin
                valid_out_d  = 1'b1;
                result_d     = quad_sum;
                overflow_d   = quad_ovf;
                term_count_d = CNT_W'(1);
                out_mode_d   = MODE_QUAD;
            end else if (s2_side_q.last) begin
                valid_out_d  = 1'b1;
                result_d     = acc_sum;
                overflow_d   = acc_ovf;
                term_count_d = cnt_inc;
                out_mode_d   = MODE_MAC;
                acc_d        = '0;
                sticky_d     = 1'b0;
                cnt_d        = '0;
            end else begin
                acc_d    = acc_sum;
                sticky_d = acc_ovf;
                cnt_d    = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_side_q    <= '0;
            s1_xx_q      <= '0;
            s1_ax_q      <= '0;
            s1_bx_q      <= '0;
            s1_a_q       <= '0;
            s1_c_q       <= '0;
            s2_side_q    <= '0;
            s2_axx_q     <= '0;
            s2_bxc_q     <= '0;
            s2_ax_q      <= '0;
            acc_q        <= '0;
            sticky_q     <= 1'b0;
            cnt_q        <= '0;
            valid_out_q  <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            term_count_q <= '0;
            out_mode_q   <= 1'b0;
        end else begin
            s1_side_q    <= s1_side_d;
            s1_xx_q      <= s1_xx_d;
            s1_ax_q      <= s1_ax_d;
            s1_bx_q      <= s1_bx_d;
            s1_a_q       <= s1_a_d;
            s1_c_q       <= s1_c_d;
            s2_side_q    <= s2_side_d;
            s2_axx_q     <= s2_axx_d;
            s2_bxc_q     <= s2_bxc_d;
            s2_ax_q      <= s2_ax_d;
            acc_q        <= acc_d;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
            valid_out_q  <= valid_out_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            term_count_q <= term_count_d;
            out_mode_q   <= out_mode_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign result     = result_q;
    assign overflow   = overflow_q;
    assign term_count = term_count_q;
    assign out_mode   = out_mode_q;

endmodule
